// File: rtl/ppd_fir_tdm_dec_pkg.sv
// Shared constants and elaboration-time helpers for the time-multiplexed polyphase decimator.
package ppd_fir_tdm_dec_pkg;

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_RND  = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    // $clog2 that never returns zero, so every counter/index keeps at least one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int unsigned div_ceil(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic int unsigned coeff_count(input int unsigned n, input int unsigned sym);
        return (sym != 0) ? div_ceil(n, 2) : n;
    endfunction

    function automatic int unsigned coeff_addr_w(input int unsigned n, input int unsigned sym);
        return clog2_min1(coeff_count(n, sym));
    endfunction

    // Map tap k onto its stored coefficient; the upper half mirrors the lower half when folded.
    function automatic int unsigned fold_tap(input int unsigned k, input int unsigned n,
                                             input int unsigned sym);
        if (k >= n) begin
            return 0;
        end
        if ((sym != 0) && (2 * k >= n)) begin
            return n - 1 - k;
        end
        return k;
    endfunction

endpackage

// File: rtl/ppd_fir_tdm_dec_coeff_rf.sv
// Coefficient register file: one write port, one combinational read port addressed by tap index.
module ppd_fir_tdm_dec_coeff_rf
    import ppd_fir_tdm_dec_pkg::*;
#(
    parameter int unsigned gp_coeff_width  = 8,
    parameter int unsigned gp_coeff_length = 17,
    parameter int unsigned gp_symmetric    = 1
) (
    input  logic                                                   i_clk,
    input  logic                                                   i_rst_an,
    input  logic                                                   i_wr,
    input  logic [coeff_addr_w(gp_coeff_length, gp_symmetric)-1:0] i_wr_addr,
    input  logic signed [gp_coeff_width-1:0]                       i_wr_data,
    input  logic [clog2_min1(gp_coeff_length)-1:0]                 i_rd_tap,
    output logic signed [gp_coeff_width-1:0]                       o_rd_data_c
);

    localparam int unsigned CW  = gp_coeff_width;
    localparam int unsigned C   = coeff_count(gp_coeff_length, gp_symmetric);
    localparam int unsigned CAW = coeff_addr_w(gp_coeff_length, gp_symmetric);

    logic signed [CW-1:0] coeff_q [C];
    logic signed [CW-1:0] coeff_d [C];
    int unsigned          rd_idx_c;

    // Out-of-range addresses are silently ignored.
    always_comb begin
        coeff_d = coeff_q;
        if (i_wr && (32'(i_wr_addr) < C)) begin
            coeff_d[i_wr_addr] = i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            for (int i = 0; i < int'(C); i++) begin
                coeff_q[i] <= '0;
            end
        end else begin
            coeff_q <= coeff_d;
        end
    end

    always_comb begin
        rd_idx_c    = fold_tap(32'(i_rd_tap), gp_coeff_length, gp_symmetric);
        o_rd_data_c = (rd_idx_c < C) ? coeff_q[CAW'(rd_idx_c)] : '0;
    end

endmodule

// File: rtl/ppd_fir_tdm_dec.sv
// Programmable polyphase decimating FIR; one shared multiplier/accumulator walks all taps per output.
module ppd_fir_tdm_dec
    import ppd_fir_tdm_dec_pkg::*;
#(
    parameter int unsigned gp_idata_width  = 8,
    parameter int unsigned gp_coeff_width  = 8,
    parameter int unsigned gp_coeff_length = 17,
    parameter int unsigned gp_dec_factor   = 4,
    parameter int unsigned gp_symmetric    = 1,
    parameter int unsigned gp_oshift       = 0,
    parameter int unsigned gp_odata_width  = 16
) (
    input  logic                                                   i_clk,
    input  logic                                                   i_rst_an,
    input  logic                                                   i_ena,
    input  logic                                                   i_clr,
    input  logic signed [gp_idata_width-1:0]                       i_data,
    input  logic                                                   i_valid,
    output logic                                                   o_ready,
    input  logic                                                   i_coeff_wr,
    input  logic [coeff_addr_w(gp_coeff_length, gp_symmetric)-1:0] i_coeff_addr,
    input  logic signed [gp_coeff_width-1:0]                       i_coeff_data,
    output logic signed [gp_odata_width-1:0]                       o_data,
    output logic                                                   o_valid,
    input  logic                                                   i_ready,
    output logic                                                   o_sat
);

    localparam int unsigned IW   = gp_idata_width;
    localparam int unsigned CW   = gp_coeff_width;
    localparam int unsigned N    = gp_coeff_length;
    localparam int unsigned D    = gp_dec_factor;
    localparam int unsigned S    = gp_oshift;
    localparam int unsigned OW   = gp_odata_width;
    localparam int unsigned PW   = IW + CW;
    localparam int unsigned AW   = PW + $clog2(N);
    localparam int unsigned RW   = AW + 1;
    localparam int unsigned YW   = (RW > OW) ? RW : OW;
    localparam int unsigned PTRW = clog2_min1(N);
    localparam int unsigned PHW  = clog2_min1(D);
    localparam int unsigned CNTW = $clog2(N + 1);
    localparam int unsigned HSH  = (S > 0) ? S - 1 : 0;

    localparam logic signed [RW-1:0] RND_HALF = (S > 0) ? (RW'(1) << HSH) : '0;
    localparam logic signed [YW-1:0] Y_MAX    = YW'({1'b0, {(OW - 1){1'b1}}});
    localparam logic signed [YW-1:0] Y_MIN    = ~Y_MAX;

    logic [1:0]           state_q, state_d;
    logic [PHW-1:0]       phase_q, phase_d;
    logic [PTRW-1:0]      wp_q, wp_d;
    logic [PTRW-1:0]      rd_q, rd_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic signed [IW-1:0] dl_q [N];
    logic signed [IW-1:0] dl_d [N];
    logic signed [PW-1:0] prod_q, prod_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [OW-1:0] o_data_q, o_data_d;
    logic                 o_sat_q, o_sat_d;
    logic                 o_valid_q, o_valid_d;
    logic                 o_ready_q, o_ready_d;

    logic                 accept_c;
    logic                 last_phase_c;
    logic                 mac_start_c;
    logic                 coeff_we_c;
    logic signed [CW-1:0] h_c;
    logic signed [IW-1:0] x_c;
    logic signed [PW-1:0] prod_c;
    logic signed [RW-1:0] sum_c;
    logic signed [RW-1:0] shr_c;
    logic signed [YW-1:0] y_ext_c;
    logic                 sat_hi_c;
    logic                 sat_lo_c;
    logic signed [OW-1:0] y_c;

    assign accept_c     = i_ena & i_valid & o_ready_q & (state_q == ST_FILL);
    assign last_phase_c = (phase_q == PHW'(D - 1));
    assign mac_start_c  = accept_c & last_phase_c;
    // Coefficients may only change while idle, and never on the edge that launches a MAC.
    assign coeff_we_c   = i_ena & ~i_clr & i_coeff_wr & (state_q == ST_FILL) & ~mac_start_c;

    ppd_fir_tdm_dec_coeff_rf #(
        .gp_coeff_width (CW),
        .gp_coeff_length(N),
        .gp_symmetric   (gp_symmetric)
    ) u_coeff_rf (
        .i_clk      (i_clk),
        .i_rst_an   (i_rst_an),
        .i_wr       (coeff_we_c),
        .i_wr_addr  (i_coeff_addr),
        .i_wr_data  (i_coeff_data),
        .i_rd_tap   (PTRW'(cnt_q)),
        .o_rd_data_c(h_c)
    );

    assign x_c    = dl_q[rd_q];
    assign prod_c = PW'(x_c) * PW'(h_c);

    // Round half-up, arithmetic shift, then clip to the output range.
    assign sum_c    = RW'(acc_q) + RND_HALF;
    assign shr_c    = sum_c >>> S;
    assign y_ext_c  = YW'(shr_c);
    assign sat_hi_c = (y_ext_c > Y_MAX);
    assign sat_lo_c = (y_ext_c < Y_MIN);
    assign y_c      = sat_hi_c ? OW'(Y_MAX) : (sat_lo_c ? OW'(Y_MIN) : OW'(y_ext_c));

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        wp_d      = wp_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        dl_d      = dl_q;
        prod_d    = prod_q;
        acc_d     = acc_q;
        o_data_d  = o_data_q;
        o_sat_d   = o_sat_q;
        o_valid_d = o_valid_q;
        o_ready_d = o_ready_q;

        if (i_clr) begin
            state_d   = ST_FILL;
            phase_d   = '0;
            wp_d      = '0;
            rd_d      = '0;
            cnt_d     = '0;
            prod_d    = '0;
            acc_d     = '0;
            o_sat_d   = 1'b0;
            o_valid_d = 1'b0;
            o_ready_d = 1'b1;
            for (int i = 0; i < int'(N); i++) begin
                dl_d[i] = '0;
            end
        end else if (i_ena) begin
            case (state_q)
                ST_FILL: begin
                    if (accept_c) begin
                        dl_d[wp_q] = i_data;
                        rd_d       = wp_q;
                        wp_d       = (wp_q == PTRW'(N - 1)) ? '0 : wp_q + 1'b1;
                        if (last_phase_c) begin
                            phase_d   = '0;
                            cnt_d     = '0;
                            state_d   = ST_MAC;
                            o_ready_d = 1'b0;
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                end
                // cnt 0..N-1 issues a product into prod_q; cnt 1..N folds it into acc.
                ST_MAC: begin
                    if (cnt_q != CNTW'(N)) begin
                        prod_d = prod_c;
                        rd_d   = (rd_q == '0) ? PTRW'(N - 1) : rd_q - 1'b1;
                    end
                    if (cnt_q == CNTW'(1)) begin
                        acc_d = AW'(prod_q);
                    end else if (cnt_q != '0) begin
                        acc_d = acc_q + AW'(prod_q);
                    end
                    if (cnt_q == CNTW'(N)) begin
                        cnt_d   = '0;
                        state_d = ST_RND;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RND: begin
                    o_data_d  = y_c;
                    o_sat_d   = sat_hi_c | sat_lo_c;
                    o_valid_d = 1'b1;
                    state_d   = ST_OUT;
                end
                ST_OUT: begin
                    if (i_ready) begin
                        o_valid_d = 1'b0;
                        o_ready_d = 1'b1;
                        state_d   = ST_FILL;
                    end
                end
                default: begin
                    state_d   = ST_FILL;
                    o_valid_d = 1'b0;
                    o_ready_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state_q   <= ST_FILL;
            phase_q   <= '0;
            wp_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            prod_q    <= '0;
            acc_q     <= '0;
            o_data_q  <= '0;
            o_sat_q   <= 1'b0;
            o_valid_q <= 1'b0;
            o_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            wp_q      <= wp_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            acc_q     <= acc_d;
            o_data_q  <= o_data_d;
            o_sat_q   <= o_sat_d;
            o_valid_q <= o_valid_d;
            o_ready_q <= o_ready_d;
        end
    end

    // Delay line, newest sample at the last written slot.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            for (int i = 0; i < int'(N); i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            dl_q <= dl_d;
        end
    end

    assign o_data  = o_data_q;
    assign o_sat   = o_sat_q;
    assign o_valid = o_valid_q;
    assign o_ready = o_ready_q;

endmodule
